// File: rtl/fir_tap_sequencer.sv
// Frame sequencer for the FIR datapath: sweeps tap/coefficient addresses, drives MAC control and the sample shift.
// Optional build macro: SYMMETRIC_FOLD_EN (linear-phase folding, TAPS/2 MAC cycles per frame, second tap address).
module fir_tap_sequencer #(
    parameter int TAPS         = 64,
    parameter int ADDR_W       = 6,
    parameter int FRAME_CYCLES = 64,
    parameter int MAC_LAT      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              sample_valid_i,
    input  logic              underrun_clr_i,
    output logic              shift_en_o,
    output logic              sample_ack_o,
    output logic [ADDR_W-1:0] read_addr_o,
    output logic [ADDR_W-1:0] read_addr_b_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic              mac_last_o,
    output logic              result_valid_o,
    output logic              busy_o,
    output logic              underrun_o
);

`ifdef SYMMETRIC_FOLD_EN
    localparam int MAC_CYC = TAPS / 2;
`else
    localparam int MAC_CYC = TAPS;
`endif
    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(MAC_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shift_en_q, shift_en_d;
    logic               mac_clr_q, mac_clr_d;
    logic               mac_en_q, mac_en_d;
    logic               mac_last_q, mac_last_d;
    logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
    logic [ADDR_W-1:0]  read_addr_b_q, read_addr_b_d;
    logic [ADDR_W-1:0]  coef_addr_q, coef_addr_d;
    logic               busy_q, busy_d;
    logic               underrun_q, underrun_d;
    logic [MAC_LAT-1:0] pipe_q, pipe_d;
    logic               mac_phase_s;

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            shift_en_q    <= 1'b0;
            mac_clr_q     <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_last_q    <= 1'b0;
            read_addr_q   <= {ADDR_W{1'b0}};
            read_addr_b_q <= {ADDR_W{1'b0}};
            coef_addr_q   <= {ADDR_W{1'b0}};
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
            pipe_q        <= {MAC_LAT{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_en_q    <= shift_en_d;
            mac_clr_q     <= mac_clr_d;
            mac_en_q      <= mac_en_d;
            mac_last_q    <= mac_last_d;
            read_addr_q   <= read_addr_d;
            read_addr_b_q <= read_addr_b_d;
            coef_addr_q   <= coef_addr_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
            pipe_q        <= pipe_d;
        end
    end

    // Next state and frame counter; enable only matters in IDLE or on the last frame cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (enable_i) begin
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC, ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = enable_i ? ST_MAC : ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (state_q == ST_MAC && cnt_q != MAC_LAST) ? ST_MAC : ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q/cnt_q.
    always_comb begin
        mac_phase_s   = (state_d == ST_MAC);
        mac_en_d      = mac_phase_s;
        mac_clr_d     = mac_phase_s && (cnt_d == {CNT_W{1'b0}});
        mac_last_d    = mac_phase_s && (cnt_d == MAC_LAST);
        shift_en_d    = (state_d != ST_IDLE) && (cnt_d == CNT_LAST);
        busy_d        = (state_d != ST_IDLE);
        read_addr_d   = mac_phase_s ? ADDR_W'(cnt_d) : {ADDR_W{1'b0}};
        coef_addr_d   = read_addr_d;
`ifdef SYMMETRIC_FOLD_EN
        read_addr_b_d = mac_phase_s ? (ADDR_W'(TAPS - 1) - ADDR_W'(cnt_d)) : {ADDR_W{1'b0}};
`else
        read_addr_b_d = {ADDR_W{1'b0}};
`endif
    end

    // Sticky underrun (set wins over clear) and the result-latency pipe.
    always_comb begin
        underrun_d = (shift_en_q & ~sample_valid_i) | (underrun_q & ~underrun_clr_i);
        pipe_d     = {MAC_LAT{1'b0}};
        pipe_d[0]  = mac_last_q;
        for (int i = 1; i < MAC_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign shift_en_o     = shift_en_q;
    // The source handshake must follow the live sample_valid, so it is gated, not registered.
    assign sample_ack_o   = shift_en_q & sample_valid_i;
    assign read_addr_o    = read_addr_q;
    assign read_addr_b_o  = read_addr_b_q;
    assign coef_addr_o    = coef_addr_q;
    assign mac_clr_o      = mac_clr_q;
    assign mac_en_o       = mac_en_q;
    assign mac_last_o     = mac_last_q;
    assign result_valid_o = pipe_q[MAC_LAT-1];
    assign busy_o         = busy_q;
    assign underrun_o     = underrun_q;

endmodule
